// File: rtl/w_univ_shift_reg_if.sv
// Bus bundle for w_univ_shift_reg: control, serial/parallel data in, and register outputs.
// The rot input exists only when W_USR_ROTATE_EN is defined.
interface w_univ_shift_reg_if #(
  parameter int WIDTH = 8
);
  logic             s_n;
  logic             r_n;
  logic [1:0]       mode;
  logic             ser_r;
  logic             ser_l;
  logic [WIDTH-1:0] d;
`ifdef W_USR_ROTATE_EN
  logic             rot;
`endif
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic             so_r;
  logic             so_l;

  modport master (
    output s_n, r_n, mode, ser_r, ser_l, d,
`ifdef W_USR_ROTATE_EN
    output rot,
`endif
    input  q, qn, so_r, so_l
  );

  modport slave (
    input  s_n, r_n, mode, ser_r, ser_l, d,
`ifdef W_USR_ROTATE_EN
    input  rot,
`endif
    output q, qn, so_r, so_l
  );
endinterface

// File: rtl/w_univ_shift_reg.sv
// WIDTH-bit universal shift register: preset/clear, hold, bidirectional shift, parallel load,
// true and complement outputs. Define W_USR_ROTATE_EN to add the rot (rotate) input.
module w_univ_shift_reg #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
  input logic                clk,
  input logic                rst_n,
  w_univ_shift_reg_if.slave  bus
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHR   = 2'b01;
  localparam logic [1:0] MODE_SHL   = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] qn_r;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] qn_next;
  logic             fill_r;
  logic             fill_l;
  logic             conflict;

  assign conflict = !bus.s_n && !bus.r_n;

`ifdef W_USR_ROTATE_EN
  assign fill_r = bus.rot ? q_r[0]       : bus.ser_r;
  assign fill_l = bus.rot ? q_r[WIDTH-1] : bus.ser_l;
`else
  assign fill_r = bus.ser_r;
  assign fill_l = bus.ser_l;
`endif

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    q_next = q_r;
    if (conflict) begin
      q_next = '1;
    end else if (!bus.s_n) begin
      q_next = PRESET_VAL;
    end else if (!bus.r_n) begin
      q_next = '0;
    end else begin
      case (bus.mode)
        MODE_LOAD: q_next = bus.d;
        MODE_SHR:  q_next = {fill_r, q_r[WIDTH-1:1]};
        MODE_SHL:  q_next = {q_r[WIDTH-2:0], fill_l};
        MODE_HOLD: q_next = q_r;
        default:   q_next = q_r;  // X/Z mode holds
      endcase
    end
  end

  // The conflict flag is the state where qn is forced high alongside q; it needs no separate flop.
  assign qn_next = conflict ? '1 : ~q_next;

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_r  <= '0;
      qn_r <= '1;
    end else begin
      q_r  <= q_next;
      qn_r <= qn_next;
    end
  end

  assign bus.q    = q_r;
  assign bus.qn   = qn_r;
  assign bus.so_r = q_r[0];
  assign bus.so_l = q_r[WIDTH-1];

endmodule
